// File: rtl/dg0045_ram_rmw.sv
// DATA_W x 2**ADDR_W data RAM with write, increment/decrement read-modify-write
// and a self-running clear sequencer that fills the array after reset or on request.
module dg0045_ram_rmw #(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              RAM_clk,
    input  logic              RAM_rst_n,
    input  logic              clear_req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              carry,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic              carry_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W:0]   rmw_res;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem [DEPTH];

    // Top bit of the widened result is the carry-out / borrow-out.
    function automatic logic [DATA_W:0] rmw_inc(input logic [DATA_W-1:0] v);
        return {1'b0, v} + (DATA_W+1)'(1);
    endfunction

    function automatic logic [DATA_W:0] rmw_dec(input logic [DATA_W-1:0] v);
        return {1'b0, v} - (DATA_W+1)'(1);
    endfunction

    assign rd_word = mem[addr];
    assign busy    = (state == CLEAR);
    // Mask possibly undefined contents while the sequencer is still filling.
    assign dout    = busy ? CLEAR_VAL : rd_word;

    always_ff @(posedge RAM_clk or negedge RAM_rst_n) begin
        if (!RAM_rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            carry   <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            carry   <= carry_next;
        end
    end

    always_ff @(posedge RAM_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        carry_next   = carry;
        mem_we       = 1'b0;
        mem_waddr    = addr;
        mem_wdata    = din;
        rmw_res      = '0;
        case (state)
            CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_ptr;
                mem_wdata    = CLEAR_VAL;
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end else begin
                    case (op)
                        OP_WRITE: mem_we = 1'b1;
                        OP_INC: begin
                            rmw_res    = rmw_inc(rd_word);
                            mem_we     = 1'b1;
                            mem_wdata  = rmw_res[DATA_W-1:0];
                            carry_next = rmw_res[DATA_W];
                        end
                        OP_DEC: begin
                            rmw_res    = rmw_dec(rd_word);
                            mem_we     = 1'b1;
                            mem_wdata  = rmw_res[DATA_W-1:0];
                            carry_next = rmw_res[DATA_W];
                        end
                        OP_NOP:  mem_we = 1'b0;
                        default: mem_we = 1'b0;
                    endcase
                end
            end
            default: state_next = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_dg0045_ram_rmw.sv
// Directed self-checking bench for dg0045_ram_rmw: default 4x32 instance plus an
// 8x8 instance with a non-zero clear value.
module tb_dg0045_ram_rmw;

    logic       clk;
    logic       rst_n, clr;
    logic [1:0] op;
    logic [4:0] addr;
    logic [3:0] din, dout;
    logic       carry, busy;

    logic       rst8_n, clr8;
    logic [1:0] op8;
    logic [2:0] addr8;
    logic [7:0] din8, dout8;
    logic       carry8, busy8;

    int checks = 0;
    int failures = 0;
    int n;

    dg0045_ram_rmw u_dut (
        .RAM_clk(clk), .RAM_rst_n(rst_n), .clear_req(clr), .op(op), .addr(addr),
        .din(din), .dout(dout), .carry(carry), .busy(busy)
    );

    dg0045_ram_rmw #(.DATA_W(8), .ADDR_W(3), .CLEAR_VAL(8'h5A)) u_dut8 (
        .RAM_clk(clk), .RAM_rst_n(rst8_n), .clear_req(clr8), .op(op8), .addr(addr8),
        .din(din8), .dout(dout8), .carry(carry8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [4:0] a, input logic [3:0] d);
        op = o; addr = a; din = d;
        step();
        op = 2'b00;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [3:0] exp);
        addr = a;
        #1;
        check(tag, 32'(dout), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; op = 2'b00; addr = '0; din = '0;
        rst8_n = 1'b0; clr8 = 1'b0; op8 = 2'b00; addr8 = '0; din8 = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_carry", 32'(carry), 32'd0);

        // 1: power-up clear
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            addr = 5'(n * 7);
            #1;
            check("clr1_dout", 32'(dout), 32'd0);
            step();
            n++;
        end
        check("clr1_len", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) rd("sweep1", 5'(a), 4'h0);

        // 2: writes
        do_op(2'b01, 5'd5, 4'hA);
        rd("wr5", 5'd5, 4'hA);
        do_op(2'b01, 5'd31, 4'hF);
        rd("wr31", 5'd31, 4'hF);
        rd("wr5_kept", 5'd5, 4'hA);

        // 3: increment with carry
        do_op(2'b01, 5'd3, 4'hE);
        op = 2'b10; addr = 5'd3; #1;
        check("inc_preedge", 32'(dout), 32'hE);
        step(); op = 2'b00;
        rd("inc1", 5'd3, 4'hF);
        check("inc1_c", 32'(carry), 32'd0);
        do_op(2'b10, 5'd3, 4'h0);
        rd("inc2", 5'd3, 4'h0);
        check("inc2_c", 32'(carry), 32'd1);
        do_op(2'b00, 5'd3, 4'h0);
        check("nop_c", 32'(carry), 32'd1);

        // 4: decrement with borrow
        do_op(2'b01, 5'd7, 4'h1);
        do_op(2'b11, 5'd7, 4'h0);
        rd("dec1", 5'd7, 4'h0);
        check("dec1_c", 32'(carry), 32'd0);
        do_op(2'b11, 5'd7, 4'h0);
        rd("dec2", 5'd7, 4'hF);
        check("dec2_c", 32'(carry), 32'd1);
        do_op(2'b01, 5'd7, 4'h4);
        rd("wr7", 5'd7, 4'h4);
        check("wr_keeps_c", 32'(carry), 32'd1);

        // 5: clear request has priority over a same-cycle write
        do_op(2'b01, 5'd1, 4'h6);
        do_op(2'b01, 5'd2, 4'h3);
        do_op(2'b01, 5'd9, 4'hC);
        clr = 1'b1; op = 2'b01; addr = 5'd2; din = 4'h9;
        step();
        clr = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            op = 2'b10; addr = 5'd9;
            step();
            n++;
        end
        op = 2'b00;
        check("clr5_len", 32'(n), 32'd32);
        check("clr5_c", 32'(carry), 32'd1);
        for (int a = 0; a < 32; a++) rd("sweep5", 5'(a), 4'h0);

        // 6: async reset in the middle of a clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_c", 32'(carry), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("clr6_len", 32'(n), 32'd32);
        rd("post6", 5'd9, 4'h0);

        // 8-bit / 8-deep instance with CLEAR_VAL 0x5A
        check("r8_c", 32'(carry8), 32'd0);
        rst8_n = 1'b1;
        addr8 = 3'd3;
        n = 0;
        while (busy8 && n < 100) begin
            #1;
            check("clr8_dout", 32'(dout8), 32'h5A);
            step();
            n++;
        end
        check("clr8_len", 32'(n), 32'd8);
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a);
            #1;
            check("sweep8", 32'(dout8), 32'h5A);
        end
        op8 = 2'b01; addr8 = 3'd4; din8 = 8'hFF;
        step();
        op8 = 2'b10;
        step();
        op8 = 2'b00;
        #1;
        check("inc8", 32'(dout8), 32'h00);
        check("inc8_c", 32'(carry8), 32'd1);
        addr8 = 3'd5;
        #1;
        check("other8", 32'(dout8), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
